// File: rtl/mux_scan_pkg.sv
// Shared widths and state encoding for the mux scan sequencer and its step timer.
package mux_scan_pkg;
  localparam int SEL_W  = 2;
  localparam int N_IN   = 4;
  localparam int HOLD_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;
endpackage

// File: rtl/step_timer.sv
// Hold counter plus step counter pacing the scan: one step_done pulse every
// HOLD_CYCLES cycles while running, last_step marking the fourth step.
module step_timer
  import mux_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic step_done,
  output logic last_step
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [SEL_W-1:0]  step_cnt;

  assign step_done = run && (hold_cnt == HOLD_LAST);
  assign last_step = (step_cnt == SEL_W'(N_IN - 1));

  // Step counter wraps 3 -> 0, so it is already at 0 when the next word starts.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hold_cnt <= '0;
      step_cnt <= '0;
    end else if (run) begin
      if (step_done) begin
        hold_cnt <= '0;
        step_cnt <= step_cnt + SEL_W'(1);
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives a latched 4-bit word into a 4:1 mux, walks the select through all
// inputs, serialises the sampled mux output and flags routing mismatches.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_data,
  output logic             in_ready,
  output logic [N_IN-1:0]  mux_in,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_out,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             flush,
  output logic             mux_err,
  input  logic             err_clr
);

  localparam logic [SEL_W-1:0] FIRST_SEL = MSB_FIRST ? SEL_W'(N_IN - 1) : '0;

  logic [0:0] state;
  logic       scan_act;
  logic       step_done;
  logic       last_step;
  logic       vld_p0;
  logic       mismatch_p0;

  assign scan_act = (state == ST_SCAN);
  assign in_ready = (state == ST_IDLE);

  step_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_step_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .run       (scan_act),
    .step_done (step_done),
    .last_step (last_step)
  );

  // Sample stage: a step ending in the same cycle as flush is dropped entirely.
  assign vld_p0      = step_done && !flush;
  assign mismatch_p0 = vld_p0 && (mux_out != mux_in[mux_sel]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      mux_in  <= '0;
      mux_sel <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state   <= ST_SCAN;
            mux_in  <= in_data;
            mux_sel <= FIRST_SEL;
          end
        end
        default: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (step_done) begin
            if (last_step) begin
              state <= ST_IDLE;
            end else if (MSB_FIRST) begin
              mux_sel <= mux_sel - SEL_W'(1);
            end else begin
              mux_sel <= mux_sel + SEL_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Output stage: registered serial bit and sticky error (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      mux_err   <= 1'b0;
    end else begin
      ser_valid <= vld_p0;
      ser_last  <= vld_p0 && last_step;
      if (vld_p0) begin
        ser_bit <= mux_out;
      end
      if (mismatch_p0) begin
        mux_err <= 1'b1;
      end else if (err_clr) begin
        mux_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: one sequencer with HOLD_CYCLES=1 (LSB first, optional faulty
// mux), one with HOLD_CYCLES=3 (MSB first, ideal mux).
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  int         n_checks = 0;
  int         n_pass   = 0;

  // Instance A: HOLD_CYCLES=1, MSB_FIRST=0
  logic       in_valid_a, in_ready_a, mux_out_a, ser_bit_a, ser_valid_a, ser_last_a;
  logic       flush_a, mux_err_a, err_clr_a, fault_a;
  logic [3:0] in_data_a, mux_in_a;
  logic [1:0] mux_sel_a;

  // Instance B: HOLD_CYCLES=3, MSB_FIRST=1
  logic       in_valid_b, in_ready_b, mux_out_b, ser_bit_b, ser_valid_b, ser_last_b;
  logic       mux_err_b;
  logic [3:0] in_data_b, mux_in_b;
  logic [1:0] mux_sel_b;

  always #5 clk = ~clk;

  // Mux models; the faulty one swaps the two select bits.
  always_comb begin
    mux_out_a = fault_a ? mux_in_a[{mux_sel_a[0], mux_sel_a[1]}] : mux_in_a[mux_sel_a];
    mux_out_b = mux_in_b[mux_sel_b];
  end

  mux_scan_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .mux_in(mux_in_a), .mux_sel(mux_sel_a),
    .mux_out(mux_out_a), .ser_bit(ser_bit_a), .ser_valid(ser_valid_a),
    .ser_last(ser_last_a), .flush(flush_a), .mux_err(mux_err_a), .err_clr(err_clr_a)
  );

  mux_scan_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .mux_in(mux_in_b), .mux_sel(mux_sel_b),
    .mux_out(mux_out_b), .ser_bit(ser_bit_b), .ser_valid(ser_valid_b),
    .ser_last(ser_last_b), .flush(1'b0), .mux_err(mux_err_b), .err_clr(1'b0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ready"}, 32'(in_ready_a), 32'd1);
    check({tag, "_muxin"}, 32'(mux_in_a), 32'd0);
    check({tag, "_sel"}, 32'(mux_sel_a), 32'd0);
    check({tag, "_bit"}, 32'(ser_bit_a), 32'd0);
    check({tag, "_valid"}, 32'(ser_valid_a), 32'd0);
    check({tag, "_last"}, 32'(ser_last_a), 32'd0);
    check({tag, "_err"}, 32'(mux_err_a), 32'd0);
  endtask

  // Full word on instance A; bits[k] / errs[k] are the expected ser_bit / mux_err after step k.
  task automatic scan_word_a(input string tag, input logic [3:0] word,
                             input logic [3:0] bits, input logic [3:0] errs);
    in_valid_a = 1'b1;
    in_data_a  = word;
    tick();
    in_valid_a = 1'b0;
    in_data_a  = ~word;
    check({tag, "_ready_lo"}, 32'(in_ready_a), 32'd0);
    check({tag, "_muxin"}, 32'(mux_in_a), 32'(word));
    check({tag, "_sel0"}, 32'(mux_sel_a), 32'd0);
    check({tag, "_nov"}, 32'(ser_valid_a), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("%s_v%0d", tag, k), 32'(ser_valid_a), 32'd1);
      check($sformatf("%s_b%0d", tag, k), 32'(ser_bit_a), 32'(bits[k]));
      check($sformatf("%s_l%0d", tag, k), 32'(ser_last_a), 32'(k == 3));
      check($sformatf("%s_e%0d", tag, k), 32'(mux_err_a), 32'(errs[k]));
    end
    check({tag, "_ready_hi"}, 32'(in_ready_a), 32'd1);
    tick();
    check({tag, "_idle_nov"}, 32'(ser_valid_a), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_b;
    reset = 1'b1;
    in_valid_a = 1'b0; in_data_a = 4'h0; flush_a = 1'b0; err_clr_a = 1'b0; fault_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = 4'h0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_a("rst");
    check("rst_b_ready", 32'(in_ready_b), 32'd1);

    // Ideal mux, word 0110 -> 0,1,1,0
    scan_word_a("w0110", 4'b0110, 4'b0110, 4'b0000);

    // Faulty mux, word 0110: swapped routing goes unnoticed
    fault_a = 1'b1;
    scan_word_a("f0110", 4'b0110, 4'b0110, 4'b0000);
    // Faulty mux, word 0010: step1 routes bit2=0 instead of bit1=1
    scan_word_a("f0010", 4'b0010, 4'b0100, 4'b1110);
    tick();
    check("err_sticky", 32'(mux_err_a), 32'd1);

    // err_clr alone
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    check("errclr_alone", 32'(mux_err_a), 32'd0);

    // err_clr coincident with the step-1 mismatch: set wins
    in_valid_a = 1'b1; in_data_a = 4'b0010;
    tick();
    in_valid_a = 1'b0;
    tick();
    check("coinc_pre", 32'(mux_err_a), 32'd0);
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    check("coinc_setwins", 32'(mux_err_a), 32'd1);
    tick();
    tick();
    check("coinc_last", 32'(ser_last_a), 32'd1);
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    check("errclr_again", 32'(mux_err_a), 32'd0);
    fault_a = 1'b0;

    // Back-to-back words with in_valid held high
    in_valid_a = 1'b1; in_data_a = 4'b0001;
    tick();
    in_data_a = 4'b1000;
    check("b2b_hold_data", 32'(mux_in_a), 32'b0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("b2b1_b%0d", k), 32'(ser_bit_a), 32'(k == 0));
      check($sformatf("b2b1_v%0d", k), 32'(ser_valid_a), 32'd1);
      check($sformatf("b2b1_rdy%0d", k), 32'(in_ready_a), 32'(k == 3));
    end
    check("b2b1_last", 32'(ser_last_a), 32'd1);
    tick();
    in_valid_a = 1'b0;
    check("b2b2_accepted", 32'(in_ready_a), 32'd0);
    check("b2b2_muxin", 32'(mux_in_a), 32'b1000);
    check("b2b2_gap_nov", 32'(ser_valid_a), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("b2b2_b%0d", k), 32'(ser_bit_a), 32'(k == 3));
      check($sformatf("b2b2_l%0d", k), 32'(ser_last_a), 32'(k == 3));
    end
    tick();

    // Flush during step 2
    in_valid_a = 1'b1; in_data_a = 4'b0110;
    tick();
    in_valid_a = 1'b0;
    tick();
    tick();
    check("fl_pre_sel", 32'(mux_sel_a), 32'd2);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("fl_ready", 32'(in_ready_a), 32'd1);
    check("fl_nov", 32'(ser_valid_a), 32'd0);
    check("fl_sel_hold", 32'(mux_sel_a), 32'd2);
    tick();
    check("fl_nov2", 32'(ser_valid_a), 32'd0);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("fl_idle_noeffect", 32'(in_ready_a), 32'd1);
    scan_word_a("w1001", 4'b1001, 4'b1001, 4'b0000);

    // Reset mid-scan after step 2 of a faulty 0010 word
    fault_a = 1'b1;
    in_valid_a = 1'b1; in_data_a = 4'b0010;
    tick();
    in_valid_a = 1'b0;
    repeat (3) tick();
    check("rs_pre_err", 32'(mux_err_a), 32'd1);
    check("rs_pre_bit", 32'(ser_bit_a), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fault_a = 1'b0;
    check_reset_a("midrst");
    tick();
    check("midrst_nov", 32'(ser_valid_a), 32'd0);

    // Instance B: HOLD_CYCLES=3, MSB first, word 1010 -> 1,0,1,0 every 3 cycles
    exp_b = 4'b0101;
    in_valid_b = 1'b1; in_data_b = 4'b1010;
    tick();
    in_valid_b = 1'b0; in_data_b = 4'b0101;
    for (int j = 0; j < 12; j++) begin
      check($sformatf("b_rdy%0d", j), 32'(in_ready_b), 32'd0);
      check($sformatf("b_sel%0d", j), 32'(mux_sel_b), 32'(3 - j / 3));
      check($sformatf("b_v%0d", j), 32'(ser_valid_b), 32'(j > 0 && j % 3 == 0));
      if (j > 0 && j % 3 == 0)
        check($sformatf("b_bit%0d", j), 32'(ser_bit_b), 32'(exp_b[j / 3 - 1]));
      check($sformatf("b_l%0d", j), 32'(ser_last_b), 32'd0);
      tick();
    end
    check("b_final_v", 32'(ser_valid_b), 32'd1);
    check("b_final_bit", 32'(ser_bit_b), 32'(exp_b[3]));
    check("b_final_last", 32'(ser_last_b), 32'd1);
    check("b_final_rdy", 32'(in_ready_b), 32'd1);
    check("b_err", 32'(mux_err_b), 32'd0);
    tick();
    check("b_idle_nov", 32'(ser_valid_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
